// File: rtl/axi_default_slave.sv
// ---------------------------------------------------------------------------
// axi_default_slave
//   AXI default-slave responder. It terminates every transaction the
//   interconnect decoder steers to the unmapped-address port and completes
//   each burst with DECERR so that no master can hang. The read and write
//   channels are fully independent.
//
// Ports
//   ACLK, ARESETn        clock; asynchronous active-low reset
//   AW*  (in)            write address; only AWID is retained
//   AWREADY (out)        high while the write FSM is idle
//   W*   (in)            write data; beats are accepted and discarded
//   WREADY (out)         high while collecting write data
//   BID/BRESP/BVALID     write response (DECERR), held until BREADY
//   AR*  (in)            read address; ARID and ARLEN are retained
//   ARREADY (out)        high while the read FSM is idle
//   RID/RDATA/RRESP/
//   RLAST/RVALID (out)   read beats (zero data, DECERR), ARLEN+1 of them
//   RREADY (in)          read data ready
// ---------------------------------------------------------------------------
module axi_default_slave #(
  parameter int unsigned ID_W   = 8,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 4
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  // write address channel
  input  logic [ID_W-1:0]     AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [LEN_W-1:0]    AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  // write data channel
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  // write response channel
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  // read address channel
  input  logic [ID_W-1:0]     ARID,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [LEN_W-1:0]    ARLEN,
  input  logic [2:0]          ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,
  // read data channel
  output logic [ID_W-1:0]     RID,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  // Address, size, burst, write data and AWLEN play no part in the response.
  logic unused_inputs;
  assign unused_inputs = ^{AWADDR, AWLEN, AWSIZE, AWBURST, WDATA, WSTRB,
                           ARADDR, ARSIZE, ARBURST};

  // -------------------------------------------------------------------------
  // Write channel
  // -------------------------------------------------------------------------
  w_state_e        w_state_q, w_state_d;
  logic [ID_W-1:0] id_w_q, id_w_d;
  logic            awready_q, wready_q, bvalid_q;
  logic [1:0]      bresp_q;

  // Write next-state: the burst ends on WLAST only, AWLEN is not counted.
  always_comb begin
    w_state_d = w_state_q;
    id_w_d    = id_w_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (AWVALID) begin
          id_w_d    = AWID;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (WVALID && WLAST) begin
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (BREADY) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write state and handshake outputs, registered from the next state.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_q <= W_IDLE;
      id_w_q    <= '0;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      id_w_q    <= id_w_d;
      awready_q <= (w_state_d == W_IDLE);
      wready_q  <= (w_state_d == W_DATA);
      bvalid_q  <= (w_state_d == W_RESP);
      bresp_q   <= (w_state_d == W_RESP) ? RESP_DECERR : RESP_OKAY;
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  // id_w_q only changes in W_IDLE, so BID is stable for the whole response.
  assign BID     = id_w_q;

  // -------------------------------------------------------------------------
  // Read channel
  // -------------------------------------------------------------------------
  r_state_e         r_state_q, r_state_d;
  logic [ID_W-1:0]  id_r_q, id_r_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             arready_q, rvalid_q, rlast_q;
  logic [1:0]       rresp_q;

  // Read next-state: emit len_q+1 beats; the counter never passes len_q,
  // so ARLEN at its maximum does not wrap.
  always_comb begin
    r_state_d  = r_state_q;
    id_r_d     = id_r_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (ARVALID) begin
          id_r_d     = ARID;
          len_d      = ARLEN;
          beat_cnt_d = '0;
          r_state_d  = R_DATA;
        end
      end
      R_DATA: begin
        if (RREADY) begin
          if (beat_cnt_q == len_q) begin
            r_state_d = R_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + LEN_W'(1);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read state and beat outputs, registered from the next state.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state_q  <= R_IDLE;
      id_r_q     <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rresp_q    <= RESP_OKAY;
    end else begin
      r_state_q  <= r_state_d;
      id_r_q     <= id_r_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      arready_q  <= (r_state_d == R_IDLE);
      rvalid_q   <= (r_state_d == R_DATA);
      rlast_q    <= (r_state_d == R_DATA) && (beat_cnt_d == len_d);
      rresp_q    <= (r_state_d == R_DATA) ? RESP_DECERR : RESP_OKAY;
    end
  end

  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RLAST   = rlast_q;
  assign RRESP   = rresp_q;
  assign RID     = id_r_q;
  assign RDATA   = '0;

endmodule

// File: tb/tb_axi_default_slave.sv
module tb_axi_default_slave;

  localparam int unsigned ID_W   = 8;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 4;

  logic                ACLK = 1'b0;
  logic                ARESETn;
  logic [ID_W-1:0]     AWID;
  logic [ADDR_W-1:0]   AWADDR;
  logic [LEN_W-1:0]    AWLEN;
  logic [2:0]          AWSIZE;
  logic [1:0]          AWBURST;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WLAST;
  logic                WVALID;
  logic                WREADY;
  logic [ID_W-1:0]     BID;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ID_W-1:0]     ARID;
  logic [ADDR_W-1:0]   ARADDR;
  logic [LEN_W-1:0]    ARLEN;
  logic [2:0]          ARSIZE;
  logic [1:0]          ARBURST;
  logic                ARVALID;
  logic                ARREADY;
  logic [ID_W-1:0]     RID;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RLAST;
  logic                RVALID;
  logic                RREADY;

  axi_default_slave #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
    .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [ID_W-1:0] id;
    logic            last;
  } r_exp_t;

  r_exp_t          exp_r[$];
  logic [ID_W-1:0] exp_b[$];

  int total = 0;
  int bad   = 0;
  int r_beats = 0;
  int b_resps = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; the monitor samples on
  // the falling edge, seeing exactly what the next rising edge will consume.
  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  task automatic push_read(input logic [ID_W-1:0] id, input int len);
    r_exp_t e;
    for (int i = 0; i <= len; i++) begin
      e.id   = id;
      e.last = (i == len);
      exp_r.push_back(e);
    end
  endtask

  // Scoreboard monitor: every visible response is checked against the head
  // of its queue (covering stability under backpressure); pop on handshake.
  always @(negedge ACLK) begin
    if (ARESETn) begin
      if (RVALID) begin
        if (exp_r.size() == 0) begin
          chk("r_unexpected", 1, 0);
        end else begin
          chk("rid", RID, exp_r[0].id);
          chk("rlast", RLAST, exp_r[0].last);
          chk("rresp", RRESP, 2'b11);
          chk("rdata", RDATA, 0);
          if (RREADY) begin
            void'(exp_r.pop_front());
            r_beats++;
          end
        end
      end else begin
        chk("rresp_idle", RRESP, 2'b00);
      end
      if (BVALID) begin
        if (exp_b.size() == 0) begin
          chk("b_unexpected", 1, 0);
        end else begin
          chk("bid", BID, exp_b[0]);
          chk("bresp", BRESP, 2'b11);
          if (BREADY) begin
            void'(exp_b.pop_front());
            b_resps++;
          end
        end
      end else begin
        chk("bresp_idle", BRESP, 2'b00);
      end
    end
  end

  int rb0;
  logic rr_pat [6];

  initial begin
    ARESETn = 1'b0;
    AWID = '0; AWADDR = 32'h8000_0000; AWLEN = '0; AWSIZE = 3'd2;
    AWBURST = 2'b01; AWVALID = 1'b0;
    WDATA = 32'hDEAD_BEEF; WSTRB = '1; WLAST = 1'b0; WVALID = 1'b0;
    BREADY = 1'b0;
    ARID = '0; ARADDR = 32'h9000_0000; ARLEN = '0; ARSIZE = 3'd2;
    ARBURST = 2'b01; ARVALID = 1'b0; RREADY = 1'b0;

    // Reset values
    cyc(); cyc();
    chk("rst_awready", AWREADY, 1);
    chk("rst_arready", ARREADY, 1);
    chk("rst_wready", WREADY, 0);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_rlast", RLAST, 0);
    chk("rst_bid", BID, 0);
    chk("rst_rid", RID, 0);
    chk("rst_bresp", BRESP, 0);
    chk("rst_rresp", RRESP, 0);
    chk("rst_rdata", RDATA, 0);
    ARESETn = 1'b1;
    cyc();

    // 1: single write, B at cycle 2
    AWID = 8'h15; AWLEN = 4'd0; AWVALID = 1'b1; BREADY = 1'b1;
    exp_b.push_back(8'h15);
    chk("t1_awready", AWREADY, 1);
    cyc();
    AWVALID = 1'b0; WVALID = 1'b1; WLAST = 1'b1;
    chk("t1_awready_busy", AWREADY, 0);
    chk("t1_wready", WREADY, 1);
    cyc();
    WVALID = 1'b0; WLAST = 1'b0;
    chk("t1_bvalid_c2", BVALID, 1);
    chk("t1_wready_off", WREADY, 0);
    cyc();
    chk("t1_awready_back", AWREADY, 1);
    chk("t1_bvalid_off", BVALID, 0);
    BREADY = 1'b0;

    // 2: read burst of 4 under backpressure
    rb0 = r_beats;
    ARID = 8'h2A; ARLEN = 4'd3; ARVALID = 1'b1;
    push_read(8'h2A, 3);
    cyc();
    ARVALID = 1'b0;
    chk("t2_rvalid_first", RVALID, 1);
    chk("t2_arready_busy", ARREADY, 0);
    rr_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      RREADY = rr_pat[i];
      cyc();
    end
    RREADY = 1'b0;
    chk("t2_beats", r_beats - rb0, 4);
    chk("t2_rvalid_done", RVALID, 0);
    chk("t2_arready_back", ARREADY, 1);

    // 3: maximum-length read, 16 beats back to back
    rb0 = r_beats;
    ARID = 8'h3C; ARLEN = 4'hF; ARVALID = 1'b1; RREADY = 1'b1;
    push_read(8'h3C, 15);
    cyc();
    ARVALID = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("t3_rvalid_streaming", RVALID, 1);
      cyc();
    end
    chk("t3_beats", r_beats - rb0, 16);
    chk("t3_arready_after", ARREADY, 1);
    chk("t3_rvalid_after", RVALID, 0);
    RREADY = 1'b0;

    // 4: simultaneous AW and AR
    AWID = 8'h01; AWLEN = 4'd1; AWVALID = 1'b1;
    ARID = 8'h02; ARLEN = 4'd0; ARVALID = 1'b1;
    RREADY = 1'b1; BREADY = 1'b1;
    exp_b.push_back(8'h01);
    push_read(8'h02, 0);
    chk("t4_both_ready", {AWREADY, ARREADY}, 2'b11);
    cyc();
    AWVALID = 1'b0; ARVALID = 1'b0;
    chk("t4_both_taken", {AWREADY, ARREADY}, 2'b00);
    WVALID = 1'b1; WLAST = 1'b0;
    cyc();
    WLAST = 1'b1;
    cyc();
    WVALID = 1'b0; WLAST = 1'b0;
    cyc(); cyc();
    chk("t4_r_drained", exp_r.size(), 0);
    chk("t4_b_drained", exp_b.size(), 0);
    BREADY = 1'b0; RREADY = 1'b0;

    // 5: B backpressure blocks a second AW
    AWID = 8'h33; AWLEN = 4'd0; AWVALID = 1'b1;
    exp_b.push_back(8'h33);
    cyc();
    AWVALID = 1'b0; WVALID = 1'b1; WLAST = 1'b1;
    cyc();
    WVALID = 1'b0; WLAST = 1'b0;
    AWID = 8'h44; AWVALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t5_bvalid_held", BVALID, 1);
      chk("t5_awready_blocked", AWREADY, 0);
      cyc();
    end
    BREADY = 1'b1;
    cyc();
    BREADY = 1'b0;
    exp_b.push_back(8'h44);
    chk("t5_awready_after_b", AWREADY, 1);
    cyc();
    AWVALID = 1'b0;
    chk("t5_second_aw_taken", WREADY, 1);
    WVALID = 1'b1; WLAST = 1'b1; BREADY = 1'b1;
    cyc();
    WVALID = 1'b0; WLAST = 1'b0;
    cyc();
    BREADY = 1'b0;
    chk("t5_b_drained", exp_b.size(), 0);

    // 6: reset in the middle of an 8-beat read
    rb0 = r_beats;
    ARID = 8'h55; ARLEN = 4'd7; ARVALID = 1'b1; RREADY = 1'b1;
    push_read(8'h55, 7);
    cyc();
    ARVALID = 1'b0;
    cyc(); cyc();
    chk("t6_beats_before_rst", r_beats - rb0, 2);
    ARESETn = 1'b0;
    #1;
    chk("t6_rvalid_async", RVALID, 0);
    exp_r.delete();
    cyc(); cyc();
    ARESETn = 1'b1;
    cyc();
    chk("t6_arready_post", ARREADY, 1);
    for (int i = 0; i < 5; i++) begin
      chk("t6_no_stale", RVALID, 0);
      cyc();
    end
    RREADY = 1'b0;
    chk("t6_beats_total", r_beats - rb0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_default_slave.md
Name: axi_default_slave

Overview:
- Default-slave responder on the slave side of the AXI interconnect.
- Terminates every transaction whose address falls outside all mapped slave ranges, i.e. those the interconnect's address decoder steers to the default-slave port.
- Completes every such burst protocol-correctly with DECERR, so no master hangs on an unmapped address.
- Read and write channels are independent and may be busy simultaneously.

Parameters:
- ID_W, 8, width of AWID/BID/ARID/RID (slave-side ID, master ID prepended by interconnect).
- ADDR_W, 32, address width (`AXI_ADDR_BITS).
- DATA_W, 32, data width (`AXI_DATA_BITS).
- LEN_W, 4, burst length field width (`AXI_LEN_BITS); beats = LEN+1.

Ports:
- ACLK  in  1  clock; all logic on its rising edge.
- ARESETn  in  1  asynchronous, active-low reset.
- AWID  in  ID_W  write address ID.
- AWADDR  in  ADDR_W  ignored beyond handshake.
- AWLEN  in  LEN_W  write burst length.
- AWSIZE  in  3  ignored.
- AWBURST  in  2  ignored.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- WDATA  in  DATA_W  discarded.
- WSTRB  in  DATA_W/8  discarded.
- WLAST  in  1  last write beat.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- BID  out  ID_W  response ID.
- BRESP  out  2  write response.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- ARID  in  ID_W  read address ID.
- ARADDR  in  ADDR_W  ignored.
- ARLEN  in  LEN_W  read burst length.
- ARSIZE  in  3  ignored.
- ARBURST  in  2  ignored.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- RID  out  ID_W  read data ID.
- RDATA  out  DATA_W  read data.
- RRESP  out  2  read response.
- RLAST  out  1  last read beat.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.

Behaviour:

Write FSM (W_IDLE, W_DATA, W_RESP):
- AWREADY = (state==W_IDLE); WREADY = (state==W_DATA); BVALID = (state==W_RESP).
- W_IDLE: on AWVALID&&AWREADY, latch AWID into id_w_q and go to W_DATA.
- W_DATA: each WVALID&&WREADY beat is accepted and discarded. A beat with WLAST=1 moves to W_RESP.
- Termination is by WLAST only. AWLEN is not counted; a WLAST that arrives early or late is not checked.
- W_RESP: BID=id_w_q, BRESP=2'b11 (DECERR). BVALID holds, with BID/BRESP stable, until BREADY. On BVALID&&BREADY go to W_IDLE.
- Minimum write turnaround: AW accept at cycle 0, WLAST beat at cycle 1, BVALID high at cycle 2.
- A new AW is not accepted before the B handshake completes.
- W data presented before AW is held off: WREADY=0 in W_IDLE.

Read FSM (R_IDLE, R_DATA):
- ARREADY = (state==R_IDLE); RVALID = (state==R_DATA).
- R_IDLE: on ARVALID&&ARREADY, latch ARID into id_r_q and ARLEN into len_q, clear beat_cnt, go to R_DATA.
- R_DATA: RID=id_r_q, RDATA=0, RRESP=2'b11, RLAST=(beat_cnt==len_q).
- On RVALID&&RREADY: if RLAST, go to R_IDLE; else beat_cnt+1.
- beat_cnt is LEN_W bits. ARLEN=15 produces 16 beats without wrap.
- Outputs are stable while RVALID=1 and RREADY=0.
- First R beat is valid the cycle after the AR handshake. Back-to-back beats when RREADY is held high.

Channel independence:
- Read and write FSMs share no state.
- Simultaneous AW and AR in the same cycle are both accepted.

Reset (asynchronous assert, synchronous release):
- Both FSMs return to IDLE.
- AWREADY=1, ARREADY=1, WREADY=0, BVALID=0, RVALID=0, RLAST=0.
- BID=0, RID=0, BRESP=2'b00, RRESP=2'b00, RDATA=0; internal registers cleared.
- Reset mid-burst abandons the burst. No BVALID/RVALID is issued for it afterwards.

RRESP and BRESP read 2'b00 whenever the corresponding VALID is low.

Test Plan:
1. Single write: AWID=8'h15, AWLEN=0; one W beat with WLAST=1; BREADY=1 -> BVALID at cycle 2 with BID=8'h15, BRESP=2'b11; AWREADY returns to 1 the cycle after the B handshake.
2. Read burst with backpressure: ARID=8'h2A, ARLEN=3; RREADY toggling 1,0,1,1,0,1 -> exactly 4 accepted beats, each RDATA=0, RRESP=2'b11, RID=8'h2A; RLAST only on the 4th; outputs stable during RREADY=0 cycles.
3. Max-length read: ARLEN=4'hF, RREADY=1 -> 16 consecutive beats, RLAST on beat 16 only, ARREADY=1 on the following cycle.
4. Concurrent traffic: AW (AWID=8'h01, AWLEN=1) and AR (ARID=8'h02, ARLEN=0) in the same cycle -> both handshake that cycle; the R beat and the B response complete independently with correct IDs.
5. B backpressure: BREADY held 0 for 5 cycles after write -> BVALID stays 1 with BID/BRESP constant; AWREADY stays 0; a second AWVALID is not accepted until after the B handshake.
6. Reset mid-burst: ARLEN=7, assert ARESETn=0 after beat 2 -> RVALID drops immediately (asynchronously); after release ARREADY=1, RVALID=0, and no stale beats appear.
